// File: rtl/ramb16_fifo_ctrl_pkg.sv
// Purpose: shared constants and helpers for the RAMB16 512x36 FIFO controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ramb16_fifo_ctrl_pkg;

    localparam int FIFO_W     = 36;
    localparam int RAM_ADDR_W = 15;
    localparam int WORD_SHIFT = 5;
    localparam int DEPTH      = 512;
    localparam int PTR_W      = 9;

    // The 36-bit aspect ratio uses address bits [13:5]; bit 14 selects a
    // cascade partner, which this controller never uses.
    function automatic logic [RAM_ADDR_W-1:0] to_ram_addr(input logic [PTR_W-1:0] ptr);
        return {1'b0, ptr, {WORD_SHIFT{1'b0}}};
    endfunction

    // Port-B read latency: one cycle for the output latch, one more when the
    // optional output register is enabled.
    function automatic int rd_lat(input int dob_reg);
        return 1 + dob_reg;
    endfunction

endpackage

// File: rtl/ramb16_fifo_outbuf.sv
// Purpose: small register FIFO that catches words returning from the RAM.
// Latency: a pushed word is visible at dout_o the cycle after push_i.
// Backpressure: none internally; the caller never pushes more than N_ENTRIES.
//
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i write side,
//        pop_i read side, dout_o head word, cnt_o number of held words.
module ramb16_fifo_outbuf
    import ramb16_fifo_ctrl_pkg::*;
#(
    parameter int N_ENTRIES = 3,
    localparam int CNT_W    = $clog2(N_ENTRIES + 1),
    localparam int PW       = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [FIFO_W-1:0] din_i,
    input  logic              pop_i,
    output logic [FIFO_W-1:0] dout_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [FIFO_W-1:0] mem_q [N_ENTRIES];
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(N_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d  = push_i ? nxt(wr_q) : wr_q;
        rd_d  = pop_i  ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Storage is cleared too so the head reads zero after reset.
            for (int i = 0; i < N_ENTRIES; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= din_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/ramb16_fifo_ctrl.sv
// Purpose: FIFO controller around one RAMB16 (512x36), FWFT valid/ready output.
// Latency: push to RD_VALID is 2+RD_LAT cycles from empty; 1 word/cycle when primed.
// Backpressure: pushes dropped (WR_ERR) while FULL; RD_READY low holds RD_DATA.
//
// Ports: CLK/RST (sync, active-high); WR_EN/WR_DATA push side with FULL/WR_ERR;
//        RD_VALID/RD_READY/RD_DATA stream; LEVEL total held words;
//        RAM_* drive port A (write) and port B (read) and take RAM_DOB/RAM_DOPB.
module ramb16_fifo_ctrl
    import ramb16_fifo_ctrl_pkg::*;
#(
    parameter int DOB_REG   = 1,
    parameter int ADDR_BITS = 9,
    parameter int OUT_DEPTH = rd_lat(DOB_REG) + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [FIFO_W-1:0]     WR_DATA,
    output logic                  FULL,
    output logic                  WR_ERR,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [FIFO_W-1:0]     RD_DATA,
    output logic [ADDR_BITS:0]    LEVEL,
    output logic                  RAM_ENA,
    output logic [3:0]            RAM_WEA,
    output logic [RAM_ADDR_W-1:0] RAM_ADDRA,
    output logic [31:0]           RAM_DIA,
    output logic [3:0]            RAM_DIPA,
    output logic                  RAM_ENB,
    output logic                  RAM_REGCEB,
    output logic                  RAM_SSRB,
    output logic [RAM_ADDR_W-1:0] RAM_ADDRB,
    input  logic [31:0]           RAM_DOB,
    input  logic [3:0]            RAM_DOPB
);

    localparam int RD_LAT = rd_lat(DOB_REG);
    localparam int BCNT_W = $clog2(OUT_DEPTH + 1);
    localparam int OCC_W  = BCNT_W + 2;

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_BITS:0]   level_q, level_d;
    logic                 full_q, full_d;
    logic                 wr_err_q;
    logic [RD_LAT-1:0]    vld_q, vld_d;

    logic                 push, issue, pop, capture;
    logic [BCNT_W-1:0]    buf_cnt;
    logic [OCC_W-1:0]     inflight, occ;

    assign push    = WR_EN & ~full_q & ~RST;
    assign pop     = RD_VALID & RD_READY;
    assign capture = vld_q[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(vld_q[i]);
    end

    // Words already promised to the buffer after this cycle's pop; a new read
    // is issued only if its return is guaranteed a free buffer slot.
    assign occ   = inflight + OCC_W'(buf_cnt) - OCC_W'(pop);
    assign issue = (ram_cnt_q != '0) & (occ < OCC_W'(OUT_DEPTH)) & ~RST;

    always_comb begin
        wr_ptr_d = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;

        ram_cnt_d = ram_cnt_q;
        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase
        full_d = (ram_cnt_d == (ADDR_BITS+1)'(DEPTH));

        // Total occupancy only moves at the two stream boundaries.
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        vld_d    = vld_q << 1;
        vld_d[0] = issue;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            vld_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            level_q   <= level_d;
            full_q    <= full_d;
            wr_err_q  <= WR_EN & full_q;
            vld_q     <= vld_d;
        end
    end

    ramb16_fifo_outbuf #(
        .N_ENTRIES (OUT_DEPTH)
    ) u_outbuf (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (capture),
        .din_i  ({RAM_DOPB, RAM_DOB}),
        .pop_i  (pop),
        .dout_o (RD_DATA),
        .cnt_o  (buf_cnt)
    );

    assign RD_VALID   = (buf_cnt != '0);
    assign FULL       = full_q;
    assign WR_ERR     = wr_err_q;
    assign LEVEL      = level_q;

    assign RAM_ENA    = push;
    assign RAM_WEA    = {4{push}};
    assign RAM_ADDRA  = to_ram_addr(wr_ptr_q);
    assign RAM_DIA    = WR_DATA[31:0];
    assign RAM_DIPA   = WR_DATA[35:32];

    assign RAM_ENB    = issue;
    assign RAM_REGCEB = 1'b1;
    // Clears the RAM output latch/register so no stale word survives reset.
    assign RAM_SSRB   = RST;
    assign RAM_ADDRB  = to_ram_addr(rd_ptr_q);

endmodule

// File: doc/ramb16_fifo_ctrl.md
Name: ramb16_fifo_ctrl

Overview:
Synchronous FIFO controller that drives one block RAM primitive configured 512x36 (READ_WIDTH/WRITE_WIDTH = 36). Port A is the write port and port B is the read port.
- Generates port addresses, byte write enables and enables for the RAM.
- Hides the RAM read latency (1 or 2 cycles, set by DOB_REG) behind a small output buffer.
- Presents a first-word-fall-through valid/ready stream downstream.
- Sits directly upstream of the RAM primitive (drives its A/B control inputs) and consumes its DOB/DOPB outputs.

Parameters:
- DOB_REG, 1, RAM port-B output register enable; must match the RAM instance. Read latency RD_LAT = 1 + DOB_REG.
- ADDR_BITS, 9, word address width (512 words at 36 bits); fixed at 9 for this RAM.
- OUT_DEPTH, RD_LAT+1, output buffer entries; sized for full throughput.

Ports:
- CLK, in, 1, single clock for all logic and both RAM ports.
- RST, in, 1, synchronous active-high reset.
- WR_EN, in, 1, push request.
- WR_DATA, in, 36, push word; [35:32] is parity.
- FULL, out, 1, RAM storage full; pushes are ignored.
- WR_ERR, out, 1, one-cycle pulse on a push while FULL.
- RD_VALID, out, 1, RD_DATA is valid.
- RD_READY, in, 1, downstream accepts the word.
- RD_DATA, out, 36, head word.
- LEVEL, out, 10, total words held (RAM + in-flight + buffer); range 0..512+OUT_DEPTH.
- RAM_ENA, RAM_WEA[3:0], RAM_ADDRA[14:0], RAM_DIA[31:0], RAM_DIPA[3:0], out, port-A drive.
- RAM_ENB, RAM_REGCEB, RAM_SSRB, RAM_ADDRB[14:0], out, port-B drive.
- RAM_DOB[31:0], RAM_DOPB[3:0], in, port-B read data.

Behaviour:
- Reset: RST is synchronous and active-high on CLK. While RST is high, all pointers, counts and the buffer are cleared. Outputs after reset:
  - FULL=0, WR_ERR=0, RD_VALID=0, LEVEL=0, RD_DATA=0.
  - RAM_ENA=0, RAM_WEA=0, RAM_ENB=0.
  - RAM_SSRB=RST, so the RAM output latches/registers clear.
  - Reset mid-operation discards all contents and all in-flight reads.
- Address map: RAM_ADDRx = {1'b0, ptr[8:0], 5'b00000}. Bit 14 is 0 (no cascade).
- Write path:
  - push = WR_EN & !FULL. RAM_ENA = push and RAM_WEA = {4{push}}, both combinational from WR_EN/FULL.
  - RAM_DIA = WR_DATA[31:0], RAM_DIPA = WR_DATA[35:32].
  - wr_ptr increments mod 512 on push.
- RAM occupancy:
  - ram_cnt (0..512) is +1 on push and -1 on issue; simultaneous push and issue leaves it unchanged.
  - FULL = (ram_cnt == 512), registered.
  - WR_ERR registered: high the cycle after WR_EN & FULL.
- Read issue:
  - issue = (ram_cnt != 0) & (inflight + buf_cnt - pop < OUT_DEPTH).
  - RAM_ENB = issue; RAM_ADDRB from rd_ptr; rd_ptr increments mod 512 on issue.
  - RAM_REGCEB = 1 constantly.
  - inflight is tracked with an RD_LAT-deep valid shift register. The returning word is captured into the buffer in the cycle RAM_DOB is valid, RD_LAT cycles after issue.
- No read/write collision: issue only reads entries written in an earlier cycle, and pushes are blocked when wr_ptr == rd_ptr with ram_cnt == 512. WRITE_MODE is therefore irrelevant.
- Output stream:
  - pop = RD_VALID & RD_READY. RD_VALID = buf_cnt != 0, and RD_DATA is the buffer head.
  - RD_DATA must hold stable while RD_VALID & !RD_READY.
  - A capture and a pop in the same cycle are both honoured.
- Latency: from empty, a push in cycle 0 gives RAM_ENB in cycle 1 and RD_VALID in cycle 2+RD_LAT (cycle 4 for DOB_REG=1). Once primed, throughput is one word per cycle.
- LEVEL = ram_cnt + inflight + buf_cnt, registered; it updates one cycle after the push or pop.

Decomposition:
- Shared package holds:
  - Constants FIFO_W=36, RAM_ADDR_W=15, WORD_SHIFT=5, DEPTH=512.
  - Function to_ram_addr(ptr).
  - rd_lat(DOB_REG) function.
- One sub-module, ramb16_fifo_outbuf: register FIFO, depth OUT_DEPTH, with push/pop/count, 36 bits wide.

Test Plan:
- DOB_REG=1: after reset, push 0x0_00000001 in cycle 0 -> RAM_ENB=1 with ADDRB=0 in cycle 1; RD_VALID=1 with RD_DATA=0x000000001 in cycle 4; LEVEL=1 from cycle 1.
- Push 512 words with RD_READY=0 -> OUT_DEPTH words are buffered and LEVEL ends at 512. Push 3 more -> FULL=1 once ram_cnt reaches 512, and WR_ERR pulses only for the pushes made while FULL=1. Final LEVEL=512+OUT_DEPTH-refused count check; data stays intact.
- Continuous push and pop, 2000 words of incrementing data with RD_READY=1 -> one word per cycle after priming, in order, no gaps; the ADDRA/ADDRB pointer wrap 511->0 is exercised.
- Random RD_READY (50%), DOB_REG=0 and DOB_REG=1 -> RD_DATA stable while stalled; scoreboard matches, including parity bits [35:32]=0xA.
- Assert RST for 1 cycle with 5 words in flight and buffered -> RD_VALID=0, LEVEL=0, FULL=0 the next cycle; old data never appears afterwards.
- Push while empty and pop in the same cycle a buffered word is captured -> buf_cnt unchanged, LEVEL correct, no word lost or duplicated.
